// File: rtl/mux_tree_pipe.sv
// Parametrised N:1 mux built as a radix-4 tree. Any tree level can be registered, and
// the select, valid and out-of-range flags travel through the pipe with the data.
module mux_tree_pipe #(
  parameter int         WIDTH     = 32,
  parameter int         N         = 16,
  parameter logic [7:0] PIPE_MASK = 8'hFF,
  localparam int LEVELS = (N <= 4)     ? 1 :
                          (N <= 16)    ? 2 :
                          (N <= 64)    ? 3 :
                          (N <= 256)   ? 4 :
                          (N <= 1024)  ? 5 :
                          (N <= 4096)  ? 6 :
                          (N <= 16384) ? 7 : 8,
  localparam int SELW   = 2 * LEVELS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  input  logic [N*WIDTH-1:0] data,
  output logic [WIDTH-1:0]   result,
  output logic               result_vld,
  output logic               result_oor
);

  localparam int LEAVES = 4 ** LEVELS;

  logic [LEAVES*WIDTH-1:0] leaves;
  logic                    oor;

  // Leaf positions beyond N read as zero, which is what makes an out-of-range select yield 0.
  always_comb begin
    // NOTE: assign a default first in always_comb so every bit is driven on every path and no latch is inferred.
    leaves              = '0;
    leaves[N*WIDTH-1:0] = data;
  end

  assign oor = 32'(sel) >= N;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NODES = 4 ** (LEVELS - 1 - k);

    logic [4*NODES*WIDTH-1:0] din;
    logic [SELW-1:2*k]        sel_i;
    logic                     vld_i;
    logic                     oor_i;
    logic [NODES*WIDTH-1:0]   mux;
    logic [NODES*WIDTH-1:0]   dout;
    logic                     vld_o;
    logic                     oor_o;

    if (k == 0) begin : g_src
      assign din   = leaves;
      assign sel_i = sel;
      assign vld_i = in_valid;
      assign oor_i = oor;
    end else begin : g_src
      assign din   = g_lvl[k-1].dout;
      assign sel_i = g_lvl[k-1].g_fwd.sel_o;
      assign vld_i = g_lvl[k-1].vld_o;
      assign oor_i = g_lvl[k-1].oor_o;
    end

    always_comb begin
      mux = '0;
      for (int n = 0; n < NODES; n++) begin
        mux[n*WIDTH +: WIDTH] = din[(4*n + int'(sel_i[2*k+1:2*k]))*WIDTH +: WIDTH];
      end
    end

    if (PIPE_MASK[k]) begin : g_reg
      // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values.
      always_ff @(posedge clk) begin
        if (rst) begin
          // NOTE: the data registers are cleared too, so result reads 0 after reset, not just result_vld.
          dout  <= '0;
          vld_o <= 1'b0;
          oor_o <= 1'b0;
        end else if (en) begin
          dout  <= mux;
          vld_o <= vld_i;
          oor_o <= oor_i;
        end
      end
    end else begin : g_comb
      assign dout  = mux;
      assign vld_o = vld_i;
      assign oor_o = oor_i;
    end

    // Select bits still needed by the levels above travel alongside this level's data.
    if (k < LEVELS - 1) begin : g_fwd
      logic [SELW-1:2*k+2] sel_o;

      if (PIPE_MASK[k]) begin : g_reg
        always_ff @(posedge clk) begin
          if (rst) begin
            sel_o <= '0;
          end else if (en) begin
            sel_o <= sel_i[SELW-1:2*k+2];
          end
        end
      end else begin : g_comb
        assign sel_o = sel_i[SELW-1:2*k+2];
      end
    end
  end

  assign result     = g_lvl[LEVELS-1].dout;
  assign result_vld = g_lvl[LEVELS-1].vld_o;
  assign result_oor = g_lvl[LEVELS-1].oor_o;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three configurations share one stimulus stream and are compared
// every cycle against a delay-line model of "capture data[sel], emerge LAT enabled cycles later".
module tb_mux_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        in_valid;
  logic [5:0]  sel;
  logic [31:0] din [64];

  logic [16*32-1:0] a_data;
  logic [10*32-1:0] b_data;
  logic [64*32-1:0] c_data;

  always_comb begin
    a_data = '0;
    b_data = '0;
    c_data = '0;
    for (int i = 0; i < 16; i++) a_data[i*32 +: 32] = din[i];
    for (int i = 0; i < 10; i++) b_data[i*32 +: 32] = din[i];
    for (int i = 0; i < 64; i++) c_data[i*32 +: 32] = din[i];
  end

  logic [31:0] a_result, b_result, c_result;
  logic        a_vld, a_oor, b_vld, b_oor, c_vld, c_oor;

  // A: N=16, both levels registered (latency 2)
  mux_tree_pipe #(.WIDTH(32), .N(16), .PIPE_MASK(8'h03)) u_a (
    .clk(clk), .rst(rst), .en(en), .sel(sel[3:0]), .in_valid(in_valid), .data(a_data),
    .result(a_result), .result_vld(a_vld), .result_oor(a_oor));

  // B: N=10, only level 1 registered (latency 1)
  mux_tree_pipe #(.WIDTH(32), .N(10), .PIPE_MASK(8'h02)) u_b (
    .clk(clk), .rst(rst), .en(en), .sel(sel[3:0]), .in_valid(in_valid), .data(b_data),
    .result(b_result), .result_vld(b_vld), .result_oor(b_oor));

  // C: N=64, fully combinational
  mux_tree_pipe #(.WIDTH(32), .N(64), .PIPE_MASK(8'h00)) u_c (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .in_valid(in_valid), .data(c_data),
    .result(c_result), .result_vld(c_vld), .result_oor(c_oor));

  typedef struct packed {
    logic [31:0] d;
    logic        v;
    logic        o;
  } txn_t;

  txn_t pa [2];
  txn_t pb [1];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // What a capture of index s on an n-input mux must produce.
  function automatic txn_t capture(int n, int s);
    txn_t t;
    t.o = (s >= n);
    t.d = t.o ? 32'h0 : din[s];
    t.v = in_valid;
    return t;
  endfunction

  task automatic cycle();
    txn_t tc;
    @(posedge clk);
    if (rst) begin
      pa[0] = '0;
      pa[1] = '0;
      pb[0] = '0;
    end else if (en) begin
      pa[1] = pa[0];
      pa[0] = capture(16, int'(sel[3:0]));
      pb[0] = capture(10, int'(sel[3:0]));
    end
    @(negedge clk);
    check("a_result", a_result, pa[1].d);
    check("a_vld", 32'(a_vld), 32'(pa[1].v));
    check("a_oor", 32'(a_oor), 32'(pa[1].o));
    check("b_result", b_result, pb[0].d);
    check("b_vld", 32'(b_vld), 32'(pb[0].v));
    check("b_oor", 32'(b_oor), 32'(pb[0].o));
    tc = capture(64, int'(sel));
    check("c_result", c_result, tc.d);
    check("c_vld", 32'(c_vld), 32'(tc.v));
    check("c_oor", 32'(c_oor), 32'(tc.o));
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 64; i++) din[i] = 32'hA0 + 32'(i);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 64; i++) din[i] = $urandom;
    sel      = 6'($urandom);
    in_valid = 1'($urandom);
  endtask

  initial begin
    // Reset state
    rand_inputs();
    rst = 1'b1;
    en  = 1'b0;
    cycle();
    check("rst_a_result", a_result, 32'h0);
    check("rst_a_vld", 32'(a_vld), 32'h0);
    check("rst_b_vld", 32'(b_vld), 32'h0);
    rst = 1'b0;
    en  = 1'b1;

    // Single capture of sel=5 emerges two cycles later for exactly one cycle
    set_ramp();
    sel      = 6'd5;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    sel      = 6'($urandom);
    cycle();
    check("t1_result", a_result, 32'hA5);
    check("t1_vld", 32'(a_vld), 32'h1);
    check("t1_oor", 32'(a_oor), 32'h0);
    sel = 6'($urandom);
    cycle();
    check("t1_vld_once", 32'(a_vld), 32'h0);

    // Back-to-back sweep with no bubbles
    for (int s = 0; s < 16; s++) begin
      sel      = 6'(s);
      in_valid = 1'b1;
      cycle();
      if (s >= 1) begin
        check("sweep_result", a_result, 32'hA0 + 32'(s - 1));
        check("sweep_vld", 32'(a_vld), 32'h1);
      end
    end
    in_valid = 1'b0;
    cycle();
    check("sweep_last", a_result, 32'hAF);

    // Out-of-range select on N=10 gives zero with oor set
    for (int i = 0; i < 64; i++) din[i] = 32'hFFFF_FFFF;
    sel      = 6'd12;
    in_valid = 1'b1;
    cycle();
    check("oor_result", b_result, 32'h0);
    check("oor_flag", 32'(b_oor), 32'h1);
    check("oor_vld", 32'(b_vld), 32'h1);
    sel = 6'd9;
    cycle();
    check("top_result", b_result, 32'hFFFF_FFFF);
    check("top_oor", 32'(b_oor), 32'h0);

    // Stall holds the pipe and drops stalled inputs
    set_ramp();
    sel      = 6'd3;
    in_valid = 1'b1;
    cycle();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      cycle();
    end
    en       = 1'b1;
    in_valid = 1'b0;
    cycle();
    check("stall_result", a_result, 32'hA3);
    check("stall_vld", 32'(a_vld), 32'h1);

    // Reset mid-flight with en=0 flushes everything
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      in_valid = 1'b1;
      cycle();
    end
    rst = 1'b1;
    en  = 1'b0;
    cycle();
    check("flush_a_result", a_result, 32'h0);
    check("flush_a_vld", 32'(a_vld), 32'h0);
    check("flush_a_oor", 32'(a_oor), 32'h0);
    check("flush_b_vld", 32'(b_vld), 32'h0);
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      in_valid = 1'b0;
      cycle();
      check("flush_a_stale", 32'(a_vld), 32'h0);
      check("flush_b_stale", 32'(b_vld), 32'h0);
    end

    // Random traffic with occasional stalls and resets
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end

    // Combinational configuration ignores rst and en
    set_ramp();
    sel      = 6'd37;
    in_valid = 1'b1;
    rst      = 1'b1;
    en       = 1'b0;
    cycle();
    check("comb_result", c_result, 32'hC5);
    check("comb_vld", 32'(c_vld), 32'h1);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
